// File: rtl/spd_pkg.sv
// Shared speed-path definitions used by the speed controller and the tick generator.
package spd_pkg;
  localparam int unsigned DIV_WIDTH = 32;
  localparam logic [DIV_WIDTH-1:0] DIV_DEFAULT = 32'h266;
  localparam logic [DIV_WIDTH-1:0] DIV_MIN = 32'd2;
  typedef logic [DIV_WIDTH-1:0] div_t;
endpackage

// File: rtl/div_clamp.sv
// Combinational clamp: raises divider requests below DIV_MIN to DIV_MIN (unsigned compare).
module div_clamp
  import spd_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter logic [WIDTH-1:0] DIV_MIN = spd_pkg::DIV_MIN
) (
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_req,
  output logic             o_clamped
);
  always_comb begin
    o_clamped = (i_div < DIV_MIN);
    o_req     = o_clamped ? DIV_MIN : i_div;
  end
endmodule

// File: rtl/clk_div_tick_gen.sv
// Period counter producing a one-cycle tick every div_active clocks and a 50 % divided clock;
// divider changes are taken only at period boundaries, while disabled, or on restart.
module clk_div_tick_gen
  import spd_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter logic [WIDTH-1:0] DIV_DEFAULT = spd_pkg::DIV_DEFAULT,
  parameter logic [WIDTH-1:0] DIV_MIN = spd_pkg::DIV_MIN
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             restart,
  input  logic [WIDTH-1:0] div_in,
  output logic             tick,
  output logic             div_clk,
  output logic [WIDTH-1:0] div_active,
  output logic             div_update,
  output logic             clamped
);
  logic [WIDTH-1:0] w_req;
  logic             w_req_clamped;
  logic             w_last;
  logic             w_load;

  logic [WIDTH-1:0] r_pending;
  logic             r_pend_clamped;
  logic [WIDTH-1:0] r_active;
  logic [WIDTH-1:0] r_cnt;
  logic             r_tick;
  logic             r_div_clk;
  logic             r_update;
  logic             r_clamped;

  div_clamp #(
    .WIDTH   (WIDTH),
    .DIV_MIN (DIV_MIN)
  ) u_clamp (
    .i_div     (div_in),
    .o_req     (w_req),
    .o_clamped (w_req_clamped)
  );

  // >= rather than == so a period shortened while paused past the new end
  // still terminates on the next enabled cycle instead of wrapping the counter.
  always_comb begin
    w_last = enable && (r_cnt >= (r_active - WIDTH'(1)));
    w_load = restart || !enable || w_last;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pending      <= DIV_DEFAULT;
      r_pend_clamped <= 1'b0;
      r_active       <= DIV_DEFAULT;
      r_cnt          <= '0;
      r_tick         <= 1'b0;
      r_div_clk      <= 1'b0;
      r_update       <= 1'b0;
      r_clamped      <= 1'b0;
    end else begin
      r_pending      <= w_req;
      r_pend_clamped <= w_req_clamped;

      if (w_load) begin
        r_active  <= r_pending;
        r_clamped <= r_pend_clamped;
        r_update  <= (r_pending != r_active);
      end else begin
        r_update  <= 1'b0;
      end

      if (restart) begin
        r_cnt     <= '0;
        r_div_clk <= 1'b0;
        r_tick    <= 1'b0;
      end else if (w_last) begin
        r_cnt     <= '0;
        r_div_clk <= ~r_div_clk;
        r_tick    <= 1'b1;
      end else if (enable) begin
        r_cnt     <= r_cnt + WIDTH'(1);
        r_tick    <= 1'b0;
      end else begin
        r_tick    <= 1'b0;
      end
    end
  end

  assign tick       = r_tick;
  assign div_clk    = r_div_clk;
  assign div_active = r_active;
  assign div_update = r_update;
  assign clamped    = r_clamped;
endmodule

// File: tb/tb_clk_div_tick_gen.sv
// Directed self-checking bench for clk_div_tick_gen; expected values are hand-derived.
module tb_clk_div_tick_gen;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        restart;
  logic [31:0] div_in;
  logic        tick;
  logic        div_clk;
  logic [31:0] div_active;
  logic        div_update;
  logic        clamped;

  int unsigned n_assert = 0;
  int unsigned n_fail = 0;

  clk_div_tick_gen #(
    .WIDTH       (32),
    .DIV_DEFAULT (32'h266),
    .DIV_MIN     (32'd2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .restart    (restart),
    .div_in     (div_in),
    .tick       (tick),
    .div_clk    (div_clk),
    .div_active (div_active),
    .div_update (div_update),
    .clamped    (clamped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // restart is held high during reset to show reset wins
  task automatic do_reset();
    reset_n = 1'b0;
    restart = 1'b1;
    step();
    step();
    restart = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_tick"}, {31'd0, tick}, 32'd0);
    chk({tag, "_divclk"}, {31'd0, div_clk}, 32'd0);
    chk({tag, "_active"}, div_active, 32'h266);
    chk({tag, "_update"}, {31'd0, div_update}, 32'd0);
    chk({tag, "_clamped"}, {31'd0, clamped}, 32'd0);
  endtask

  task automatic load_idle(input logic [31:0] p);
    enable = 1'b0;
    div_in = p;
    step();
    step();
    chk($sformatf("load_active_%0d", p), div_active, p);
  endtask

  initial begin
    logic exp_t;
    logic exp_c;

    reset_n = 1'b0;
    enable  = 1'b1;
    restart = 1'b0;
    div_in  = 32'h266;

    // Test 1: default period out of reset
    do_reset();
    chk_reset_state("t1_rst");
    for (int k = 1; k <= 1228; k++) begin
      step();
      exp_t = (k == 614) || (k == 1228);
      exp_c = (k >= 614) && (k < 1228);
      chk($sformatf("t1_tick@%0d", k), {31'd0, tick}, {31'd0, exp_t});
      chk($sformatf("t1_divclk@%0d", k), {31'd0, div_clk}, {31'd0, exp_c});
      chk($sformatf("t1_update@%0d", k), {31'd0, div_update}, 32'd0);
    end

    // Test 2: P=10, request 4 mid-period
    do_reset();
    load_idle(32'd10);
    chk("t2_update_on_load", {31'd0, div_update}, 32'd1);
    enable = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      step();
      exp_t = (k == 10) || (k == 14) || (k == 18);
      chk($sformatf("t2_tick@%0d", k), {31'd0, tick}, {31'd0, exp_t});
      chk($sformatf("t2_update@%0d", k), {31'd0, div_update}, {31'd0, (k == 10)});
      if (k == 9) chk("t2_active_old", div_active, 32'd10);
      if (k == 10) chk("t2_active_new", div_active, 32'd4);
      if (k == 3) div_in = 32'd4;
    end

    // Test 3: clamp while disabled
    enable = 1'b0;
    div_in = 32'd0;
    step(); step();
    chk("t3_active_0", div_active, 32'd2);
    chk("t3_clamped_0", {31'd0, clamped}, 32'd1);
    chk("t3_update_0", {31'd0, div_update}, 32'd1);
    div_in = 32'd1;
    step(); step();
    chk("t3_active_1", div_active, 32'd2);
    chk("t3_clamped_1", {31'd0, clamped}, 32'd1);
    chk("t3_update_1", {31'd0, div_update}, 32'd0);
    div_in = 32'hFFFF_FFFF;
    step();
    chk("t3_active_lat1", div_active, 32'd2);
    step();
    chk("t3_active_max", div_active, 32'hFFFF_FFFF);
    chk("t3_clamped_max", {31'd0, clamped}, 32'd0);
    chk("t3_update_max", {31'd0, div_update}, 32'd1);

    // Test 4: P=8, pause 5 cycles at cnt=5
    do_reset();
    load_idle(32'd8);
    enable = 1'b1;
    for (int k = 1; k <= 29; k++) begin
      step();
      exp_t = (k == 8) || (k == 21) || (k == 29);
      chk($sformatf("t4_tick@%0d", k), {31'd0, tick}, {31'd0, exp_t});
      enable = !((k + 1 >= 14) && (k + 1 <= 18));
    end
    enable = 1'b1;

    // Test 5: P=6, restart mid-period and on a terminal edge
    do_reset();
    load_idle(32'd6);
    enable = 1'b1;
    for (int k = 1; k <= 29; k++) begin
      step();
      exp_t = (k == 6) || (k == 17) || (k == 29);
      exp_c = ((k >= 6) && (k <= 10)) || ((k >= 17) && (k <= 22)) || (k == 29);
      chk($sformatf("t5_tick@%0d", k), {31'd0, tick}, {31'd0, exp_t});
      chk($sformatf("t5_divclk@%0d", k), {31'd0, div_clk}, {31'd0, exp_c});
      restart = (k + 1 == 11) || (k + 1 == 23);
    end
    restart = 1'b0;

    // Test 6: reset mid-period discards state and in-flight request
    do_reset();
    load_idle(32'd100);
    enable = 1'b1;
    for (int k = 1; k <= 30; k++) step();
    div_in  = 32'd50;
    reset_n = 1'b0;
    step();
    chk_reset_state("t6_rst");
    reset_n = 1'b1;
    for (int k = 1; k <= 614; k++) begin
      step();
      chk($sformatf("t6_tick@%0d", k), {31'd0, tick}, {31'd0, (k == 614)});
      if (k == 614) begin
        chk("t6_update", {31'd0, div_update}, 32'd1);
        chk("t6_active", div_active, 32'd50);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
